// File: rtl/dcm_ramp_scheduler.sv
// Steps a DCM multiplier toward its target in bounded increments, waiting for
// lock and a dwell period between steps. Over-temperature or a lock timeout
// redirects the ramp to a safe multiplier.
//   state      | meaning
//   ST_IDLE    | compare effective target with current multiplier
//   ST_REQ     | prog_req held until the programmer acknowledges
//   ST_WAIT_LOCK | waiting for dcm_locked, bounded by the lock timer
//   ST_DWELL   | holding the new multiplier before the next step
module dcm_ramp_scheduler #(
    parameter int MAXIMUM_MULTIPLIER = 88,
    parameter int MINIMUM_MULTIPLIER = 2,
    parameter int INITIAL_MULTIPLIER = 60,
    parameter int STEP               = 4,
    parameter int SAFE_MULTIPLIER    = 20,
    parameter int DWELL_CYCLES       = 1000,
    parameter int LOCK_TIMEOUT       = 65535
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] target_mult,
    input  logic       target_valid,
    input  logic       over_temp,
    input  logic       dcm_locked,
    output logic       prog_req,
    output logic [7:0] prog_mult,
    input  logic       prog_ack,
    output logic [7:0] current_mult,
    output logic       ramp_done,
    output logic       fault
);

    localparam int TW = (LOCK_TIMEOUT < 1) ? 1 : $clog2(LOCK_TIMEOUT + 1);
    localparam int DW = (DWELL_CYCLES < 1) ? 1 : $clog2(DWELL_CYCLES + 1);
    localparam logic [7:0]  MAX8  = 8'(MAXIMUM_MULTIPLIER);
    localparam logic [7:0]  MIN8  = 8'(MINIMUM_MULTIPLIER);
    localparam logic [7:0]  INIT8 = 8'(INITIAL_MULTIPLIER);
    localparam logic [7:0]  STEP8 = 8'(STEP);
    localparam logic [7:0]  SAFE8 = 8'(SAFE_MULTIPLIER);
    localparam logic [31:0] LT_U  = 32'(LOCK_TIMEOUT);
    localparam logic [31:0] DWL_U = 32'(DWELL_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT_LOCK, ST_DWELL} state_e;

    state_e          state_q, state_d;
    logic [7:0]      target_q, target_d;
    logic [7:0]      prog_mult_q, prog_mult_d;
    logic            prog_req_q, prog_req_d;
    logic [7:0]      current_mult_q, current_mult_d;
    logic            fault_q, fault_d;
    logic [TW-1:0]   lock_tmr_q, lock_tmr_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic            over_temp_q;
    logic [7:0]      eff_target, diff, step_mult, clamped;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            target_q       <= INIT8;
            prog_mult_q    <= '0;
            prog_req_q     <= 1'b0;
            current_mult_q <= '0;
            fault_q        <= 1'b0;
            lock_tmr_q     <= '0;
            dwell_q        <= '0;
            over_temp_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            prog_mult_q    <= prog_mult_d;
            prog_req_q     <= prog_req_d;
            current_mult_q <= current_mult_d;
            fault_q        <= fault_d;
            lock_tmr_q     <= lock_tmr_d;
            dwell_q        <= dwell_d;
            over_temp_q    <= over_temp;
        end
    end

    assign eff_target = (over_temp || fault_q) ? SAFE8 : target_q;

    always_comb begin
        clamped = target_mult;
        if (target_mult > MAX8) clamped = MAX8;
        else if (target_mult < MIN8) clamped = MIN8;
    end

    // One bounded step toward the effective target; never passes it.
    always_comb begin
        diff      = '0;
        step_mult = current_mult_q;
        if (eff_target > current_mult_q) begin
            diff      = eff_target - current_mult_q;
            step_mult = current_mult_q + ((diff > STEP8) ? STEP8 : diff);
        end else begin
            diff      = current_mult_q - eff_target;
            step_mult = current_mult_q - ((diff > STEP8) ? STEP8 : diff);
        end
    end

    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        prog_mult_d    = prog_mult_q;
        prog_req_d     = prog_req_q;
        current_mult_d = current_mult_q;
        fault_d        = fault_q;
        lock_tmr_d     = lock_tmr_q;
        dwell_d        = dwell_q;

        if (target_valid) begin
            target_d = clamped;
            fault_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (eff_target != current_mult_q) begin
                    state_d     = ST_REQ;
                    prog_req_d  = 1'b1;
                    prog_mult_d = step_mult;
                end
            end
            ST_REQ: begin
                if (prog_ack) begin
                    state_d    = ST_WAIT_LOCK;
                    prog_req_d = 1'b0;
                    lock_tmr_d = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (dcm_locked) begin
                    state_d        = ST_DWELL;
                    current_mult_d = prog_mult_q;
                    dwell_d        = '0;
                end else if (32'(lock_tmr_q) + 32'd1 >= LT_U) begin
                    // A timeout outranks a same-cycle target_valid clear.
                    state_d = ST_IDLE;
                    fault_d = 1'b1;
                end else if (lock_tmr_q != {TW{1'b1}}) begin
                    lock_tmr_d = lock_tmr_q + TW'(1);
                end
            end
            ST_DWELL: begin
                if (over_temp && !over_temp_q) begin
                    state_d = ST_IDLE;
                end else if (!dcm_locked) begin
                    dwell_d = '0;
                end else if (32'(dwell_q) + 32'd1 >= DWL_U) begin
                    state_d = ST_IDLE;
                end else if (dwell_q != {DW{1'b1}}) begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign prog_req     = prog_req_q;
    assign prog_mult    = prog_mult_q;
    assign current_mult = current_mult_q;
    assign fault        = fault_q;
    assign ramp_done    = (state_q == ST_IDLE) && (current_mult_q == eff_target);

endmodule

// File: tb/tb_dcm_ramp_scheduler.sv
// Directed bench for dcm_ramp_scheduler: transaction-level ramp model checked
// every cycle, plus literal expectations for each ramp scenario.
`timescale 1ns/1ps
module tb_dcm_ramp_scheduler;

    localparam int LT   = 40;
    localparam int DWL  = 8;
    localparam int SAFE = 20;
    localparam int INIT = 60;
    localparam int STP  = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] target_mult = '0;
    logic       target_valid = 1'b0;
    logic       over_temp = 1'b0;
    logic       dcm_locked = 1'b1;
    logic       prog_ack = 1'b0;
    logic       prog_req, ramp_done, fault;
    logic [7:0] prog_mult, current_mult;

    bit resp_en = 1'b1;
    bit spur_ack = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    int seq[$];

    int m_cur, m_target, m_pend, m_req_val, m_cnt, exp_step, eff;
    bit m_fault, m_wait, prev_req, tmo;

    dcm_ramp_scheduler #(.DWELL_CYCLES(DWL), .LOCK_TIMEOUT(LT)) dut (
        .clk(clk), .reset_n(reset_n), .target_mult(target_mult),
        .target_valid(target_valid), .over_temp(over_temp),
        .dcm_locked(dcm_locked), .prog_req(prog_req), .prog_mult(prog_mult),
        .prog_ack(prog_ack), .current_mult(current_mult),
        .ramp_done(ramp_done), .fault(fault)
    );

    initial forever #5 clk = ~clk;

    // Programmer stand-in: one-cycle acknowledge per request.
    initial forever begin
        @(posedge clk);
        #1;
        prog_ack = (resp_en && prog_req && !prog_ack) || spur_ack;
    end

    function automatic int model_step(input int cur, input int tgt);
        int d;
        d = tgt - cur;
        if (d > STP) d = STP;
        if (d < -STP) d = -STP;
        return cur + d;
    endfunction

    function automatic int model_clamp(input int v);
        if (v > 88) return 88;
        if (v < 2) return 2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_target(input int v);
        @(posedge clk);
        #1;
        target_mult  = 8'(v);
        target_valid = 1'b1;
        @(posedge clk);
        #1;
        target_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        repeat (3) @(negedge clk);
        while (ramp_done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, ramp_done, 1);
    endtask

    task automatic wait_cur(input string name, input int v, input int budget);
        int k;
        k = 0;
        while (current_mult !== 8'(v) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, current_mult, v);
    endtask

    task automatic wait_ack(input string name);
        int k;
        k = 0;
        while (prog_ack !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check(name, prog_ack, 1);
    endtask

    task automatic check_release(input string name);
        int k;
        k = 0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        while (prog_req !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check({name, " latency<=2"}, k <= 2, 1);
        check({name, " first step"}, prog_mult, 4);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!reset_n) begin
                    m_cur = 0; m_target = INIT; m_fault = 1'b0;
                    m_wait = 1'b0; m_cnt = 0; prev_req = 1'b0;
                end else begin
                    check("current_mult track", current_mult, m_cur);
                    check("fault track", fault, m_fault);
                    if (prog_req && !prev_req) begin
                        check("step value", prog_mult, exp_step);
                        check("step moves", prog_mult != current_mult, 1);
                        m_req_val = exp_step;
                        seq.push_back(int'(prog_mult));
                    end else if (prog_req) begin
                        check("prog_mult stable", prog_mult, m_req_val);
                    end
                    eff = (over_temp || m_fault) ? SAFE : m_target;
                    exp_step = model_step(m_cur, eff);
                    tmo = 1'b0;
                    if (prog_req && prog_ack) begin
                        m_wait = 1'b1; m_cnt = 0; m_pend = m_req_val;
                    end else if (m_wait) begin
                        if (dcm_locked) begin
                            m_cur = m_pend; m_wait = 1'b0;
                        end else begin
                            m_cnt++;
                            if (m_cnt >= LT) begin
                                tmo = 1'b1; m_wait = 1'b0;
                            end
                        end
                    end
                    if (target_valid) m_target = model_clamp(int'(target_mult));
                    if (tmo) m_fault = 1'b1;
                    else if (target_valid) m_fault = 1'b0;
                    prev_req = prog_req;
                end
            end
            begin
                int k, bad;
                bit saw;
                #3 reset_n = 1'b0;
                cyc(3);
                check("rst prog_req", prog_req, 0);
                check("rst prog_mult", prog_mult, 0);
                check("rst current_mult", current_mult, 0);
                check("rst ramp_done", ramp_done, 0);
                check("rst fault", fault, 0);

                // Power-up ramp to the initial multiplier.
                seq.delete();
                check_release("release");
                wait_cur("reach 60", 60, 400);
                check("done low in dwell", ramp_done, 0);
                wait_done("ramp 60 done", 100);
                check("ramp 60 cur", current_mult, 60);
                check("ramp 60 steps", seq.size(), 15);
                bad = 0;
                foreach (seq[i]) if (seq[i] != 4 * (i + 1)) bad++;
                check("ramp 60 sequence errors", bad, 0);

                // Acknowledge with no request outstanding.
                @(negedge clk); spur_ack = 1'b1;
                @(negedge clk); spur_ack = 1'b0;
                saw = 1'b0;
                repeat (6) begin @(negedge clk); if (prog_req) saw = 1'b1; end
                check("spurious ack ignored", saw, 0);
                check("spurious ack done", ramp_done, 1);

                // Over-temperature aborts dwell and heads to the safe value.
                seq.delete();
                set_target(64);
                wait_cur("reach 64", 64, 60);
                @(posedge clk); #1 over_temp = 1'b1;
                k = 0;
                while (prog_req !== 1'b1 && k < 20) begin @(negedge clk); k++; end
                check("dwell abort latency", k, 3);
                check("abort first step", prog_mult, 60);
                wait_done("hot ramp done", 300);
                check("hot cur", current_mult, SAFE);
                check("hot steps", seq.size(), 12);
                check("hot last", seq[seq.size() - 1], SAFE);
                set_target(60);
                cyc(20);
                check("hot target deferred", current_mult, SAFE);
                check("hot still done", ramp_done, 1);
                seq.delete();
                @(posedge clk); #1 over_temp = 1'b0;
                wait_done("cool ramp done", 300);
                check("cool cur", current_mult, 60);
                check("cool steps", seq.size(), 10);

                // Over-range request clamps to the maximum.
                seq.delete();
                set_target(200);
                wait_done("clamp hi done", 300);
                check("clamp hi cur", current_mult, 88);
                check("clamp hi steps", seq.size(), 7);
                check("clamp hi first", seq[0], 64);
                check("clamp hi last", seq[6], 88);
                set_target(60);
                wait_done("back to 60", 300);

                // Zero request clamps to the minimum with a short final step.
                seq.delete();
                set_target(0);
                wait_done("clamp lo done", 400);
                check("clamp lo cur", current_mult, 2);
                check("clamp lo steps", seq.size(), 15);
                check("clamp lo first", seq[0], 56);
                check("clamp lo penult", seq[13], 4);
                check("clamp lo last", seq[14], 2);

                // Lock never arrives: timeout, fault, fall back to safe value.
                seq.delete();
                dcm_locked = 1'b0;
                set_target(6);
                wait_ack("timeout ack seen");
                k = 0;
                while (fault !== 1'b1 && k < 100) begin @(negedge clk); k++; end
                check("timeout latency", k, LT + 1);
                check("timeout cur kept", current_mult, 2);
                @(posedge clk); #1 dcm_locked = 1'b1;
                wait_done("fault ramp done", 300);
                check("fault ramp cur", current_mult, SAFE);
                check("fault sticky", fault, 1);
                check("fault ramp steps", seq.size(), 6);
                check("fault ramp last", seq[5], SAFE);

                // New target clears fault; reset lands while waiting for lock.
                dcm_locked = 1'b0;
                set_target(60);
                check("fault cleared", fault, 0);
                wait_ack("wait-lock ack seen");
                cyc(3);
                check("in wait_lock req low", prog_req, 0);
                #1 reset_n = 1'b0;
                #1;
                check("async rst prog_req", prog_req, 0);
                check("async rst prog_mult", prog_mult, 0);
                check("async rst current_mult", current_mult, 0);
                check("async rst ramp_done", ramp_done, 0);
                check("async rst fault", fault, 0);
                dcm_locked = 1'b1;
                saw = 1'b0;
                repeat (3) begin @(negedge clk); if (prog_req) saw = 1'b1; end
                check("no req in reset", saw, 0);
                check_release("re-release");
                wait_done("re-ramp done", 400);
                check("re-ramp cur", current_mult, 60);
            end
        join_any
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dcm_ramp_scheduler.md
DCM_RAMP_SCHEDULER -- requirements
Module: dcm_ramp_scheduler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the ports listed below (clock and reset first).
REQ-002 Parameter MAXIMUM_MULTIPLIER, default 88: upper clamp for any requested multiplier.
REQ-003 Parameter MINIMUM_MULTIPLIER, default 2: lower clamp.
REQ-004 Parameter INITIAL_MULTIPLIER, default 60: first target after reset.
REQ-005 Parameter STEP, default 4: maximum multiplier change per programming operation.
REQ-006 Parameter SAFE_MULTIPLIER, default 20: fallback target on over-temperature or fault.
REQ-007 Parameter DWELL_CYCLES, default 1000: cycles to hold after lock before the next step.
REQ-008 Parameter LOCK_TIMEOUT, default 65535: cycles allowed between prog_ack and dcm_locked.
REQ-009 clk  in  1  system clock.
REQ-010 reset_n  in  1  asynchronous, active-low reset.
REQ-011 target_mult  in  8  requested multiplier; sampled only when target_valid=1.
REQ-012 target_valid  in  1  one-cycle strobe that loads a new target.
REQ-013 over_temp  in  1  level input; while high, the effective target is SAFE_MULTIPLIER.
REQ-014 dcm_locked  in  1  DCM lock status (already synchronised to clk).
REQ-015 prog_req  out  1  request to the DCM programmer; held until acknowledged.
REQ-016 prog_mult  out  8  multiplier to program; stable while prog_req=1.
REQ-017 prog_ack  in  1  one-cycle pulse from the programmer when programming completes.
REQ-018 current_mult  out  8  last multiplier successfully programmed and locked.
REQ-019 ramp_done  out  1  high when current_mult equals the effective target and the state is IDLE.
REQ-020 fault  out  1  sticky lock-timeout flag; cleared only by reset or by a target_valid strobe.

Function
REQ-021 Target register: loaded on target_valid with target_mult clamped to [MINIMUM_MULTIPLIER, MAXIMUM_MULTIPLIER].
REQ-022 Effective target: SAFE_MULTIPLIER while over_temp=1 or fault=1; otherwise the target register.
REQ-023 States SHALL be IDLE, REQ, WAIT_LOCK, DWELL.
REQ-024 IDLE->REQ occurs when effective target != current_mult.
  - On that transition, prog_mult = current_mult ± min(STEP, |difference|), moving toward the target.
  - Arithmetic is 8-bit unsigned with no wrap; the step never overshoots the target.
REQ-025 In REQ, prog_req=1.
  - prog_mult SHALL NOT change while in REQ.
  - On prog_ack: prog_req drops the same cycle the state is left (registered, so low on the next cycle), the lock timer clears, and the state goes to WAIT_LOCK.
REQ-026 WAIT_LOCK: on dcm_locked=1, current_mult<=prog_mult, the dwell counter clears, and the state goes to DWELL.
  - If the timer reaches LOCK_TIMEOUT first: fault<=1, current_mult is unchanged, and the state goes to IDLE.
REQ-027 DWELL: count DWELL_CYCLES cycles, then go to IDLE.
  - dcm_locked=0 during DWELL restarts the dwell count.
REQ-028 Over-temperature priority: a rising over_temp during DWELL aborts the dwell immediately and goes to IDLE.
  - REQ and WAIT_LOCK are never aborted; the operation in progress completes first.
REQ-029 A target_valid during any state updates only the target register; the new target takes effect at the next IDLE evaluation.
REQ-030 target_valid and a timeout in the same cycle: fault is set (the timeout wins); the target is still loaded.
REQ-031 A prog_ack outside the REQ state SHALL be ignored.
REQ-032 Counters SHALL saturate and never wrap.

Reset
REQ-033 While reset_n=0, the outputs SHALL be:
  - prog_req=0, prog_mult=0, current_mult=0, ramp_done=0, fault=0
  - state=IDLE, target register=INITIAL_MULTIPLIER, counters=0
REQ-034 A reset asserted mid-operation SHALL abandon the operation immediately.
  - After reset release, ramping restarts from current_mult=0 toward INITIAL_MULTIPLIER.
  - The first step is prog_mult=4 (with STEP=4).
REQ-035 After reset release, the first prog_req SHALL assert no later than 2 cycles after reset_n rises.

Verification
REQ-036 Reset release with prog_ack and lock returned promptly -> prog_mult sequence 4,8,...,60 (15 steps), then ramp_done=1 and current_mult=60.
REQ-037 From current_mult=60, target_valid with target_mult=200 -> clamped to 88; steps 64..88 (7 steps), with prog_mult=88 on the last step.
REQ-038 From current_mult=60, target_valid with target_mult=0 -> target 2; downward steps 56..4, then a final step to 2.
REQ-039 From current_mult=60, over_temp=1 during DWELL -> DWELL abandoned at once; steps 56..20.
  - Deassert over_temp -> the block ramps back to the stored target.
REQ-040 dcm_locked held 0 after a prog_ack -> after LOCK_TIMEOUT cycles, fault=1 with current_mult unchanged.
  - The block then ramps toward SAFE_MULTIPLIER.
  - A subsequent target_valid clears fault.
REQ-041 Reset pulse asserted in WAIT_LOCK -> all outputs return to their reset values within the same cycle (asynchronous); no spurious prog_req.
